// File: rtl/clockbox_pkg.sv
// Shared constants for the clockbox: button indices on the io_in pins
// and the default cycle counts at the nominal 10 kHz system clock.
package clockbox_pkg;

    localparam int NUM_BTN   = 4;

    localparam int BTN_MODE  = 0;
    localparam int BTN_POWER = 1;
    localparam int BTN_STOP  = 2;
    localparam int BTN_START = 3;

    localparam int CLK_HZ              = 10000;
    localparam int DEBOUNCE_CYCLES_DEF = 200;    // 20 ms at CLK_HZ
    localparam int LONG_CYCLES_DEF     = 20000;  // 2 s at CLK_HZ

endpackage

// File: rtl/btn_channel.sv
// One button channel: two-flop synchronizer, debounce counter,
// hold counter and single-cycle press/release/long-press pulses.
// All outputs are registered; nothing from i_raw reaches them combinationally.
module btn_channel
    import clockbox_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long_press
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_PRE  = HOLD_W'(LONG_CYCLES - 1);

    logic              r_sync1;
    logic              r_sync2;
    logic [DB_W-1:0]   r_db_cnt;
    logic              r_level;
    logic              r_press;
    logic              r_release;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_long;

    logic w_diff;
    logic w_accept;

    assign w_diff   = (r_sync2 != r_level);
    assign w_accept = w_diff && (r_db_cnt == DB_LAST);

    // Bring the asynchronous pin into the clock domain.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a level change only after it has been stable long enough;
    // any return to the current level restarts the count.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_db_cnt  <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            if (!w_diff) begin
                r_db_cnt <= '0;
            end else if (w_accept) begin
                r_db_cnt  <= '0;
                r_level   <= r_sync2;
                r_press   <= r_sync2;
                r_release <= ~r_sync2;
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end
        end
    end

    // Count how long the debounced level has been high; saturating at the
    // limit means the long pulse can fire only once per press.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_hold_cnt <= '0;
            r_long     <= 1'b0;
        end else begin
            r_long <= 1'b0;
            if (!r_level || w_accept) begin
                r_hold_cnt <= '0;
            end else if (r_hold_cnt != HOLD_MAX) begin
                r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                r_long     <= (r_hold_cnt == HOLD_PRE);
            end
        end
    end

    assign o_level      = r_level;
    assign o_press      = r_press;
    assign o_release    = r_release;
    assign o_long_press = r_long;

endmodule

// File: rtl/clockbox_btn_conditioner.sv
// Input conditioning for the four clockbox push-buttons.
// Bit order on every vector is {start, stop, power, mode}.
module clockbox_btn_conditioner
    import clockbox_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [NUM_BTN-1:0] i_btn_raw,
    output logic [NUM_BTN-1:0] o_btn_level,
    output logic [NUM_BTN-1:0] o_press,
    output logic [NUM_BTN-1:0] o_release,
    output logic [NUM_BTN-1:0] o_long_press
);

    // Channels are identical and independent: no priority, no masking.
    for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES)
        ) u_chan (
            .i_clock      (i_clock),
            .i_reset      (i_reset),
            .i_raw        (i_btn_raw[g]),
            .o_level      (o_btn_level[g]),
            .o_press      (o_press[g]),
            .o_release    (o_release[g]),
            .o_long_press (o_long_press[g])
        );
    end

endmodule

// File: tb/tb_clockbox_btn_conditioner.sv
// Directed bench for clockbox_btn_conditioner at default parameters.
// Edge k after a raw change is the (k+1)-th tick, so a pulse at edge 201
// is seen at cyc == mark + 202.
module tb_clockbox_btn_conditioner;
    import clockbox_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] raw;
    logic [3:0] level;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] lng;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int mark  = 0;
    int excl  = 0;
    int pc [4];
    int rc [4];
    int lc [4];
    int pa [4];
    int ra [4];
    int la [4];

    clockbox_btn_conditioner dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_btn_raw    (raw),
        .o_btn_level  (level),
        .o_press      (press),
        .o_release    (rel),
        .o_long_press (lng)
    );

    always #5 clk = ~clk;

    task automatic clr();
        for (int i = 0; i < 4; i++) begin
            pc[i] = 0; rc[i] = 0; lc[i] = 0;
            pa[i] = -1; ra[i] = -1; la[i] = -1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 4; i++) begin
            if (press[i]) begin pc[i]++; pa[i] = cyc; end
            if (rel[i])   begin rc[i]++; ra[i] = cyc; end
            if (lng[i])   begin lc[i]++; la[i] = cyc; end
        end
        if (((press & rel) != 4'b0) || ((press & lng) != 4'b0)) excl++;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        clr();
        // Reset with all pins held high
        rst = 1'b1;
        raw = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst_outs", {16'h0, level, press, rel, lng}, 32'h0);
        end
        rst  = 1'b0;
        mark = cyc;
        clr();
        run(201);
        chk("rst_no_early", pc[0] + pc[1] + pc[2] + pc[3], 0);
        tick();
        chk("rst_press_201", {28'h0, press}, 32'hF);
        run(100);
        chk("rst_press_once", pc[0] + pc[1] + pc[2] + pc[3], 4);
        raw = 4'b0000;
        mark = cyc;
        run(250);
        chk("rst_release_at", ra[0], mark + 202);
        chk("rst_level_low", {28'h0, level}, 32'h0);

        // Clean press on mode for 10000 cycles
        clr();
        raw  = 4'b0001;
        mark = cyc;
        run(202);
        chk("clean_level_201", {28'h0, level}, 32'h1);
        run(10000 - 202);
        chk("clean_press_cnt", pc[0], 1);
        chk("clean_press_at", pa[0], mark + 202);
        chk("clean_no_drop", rc[0], 0);
        chk("clean_level_end", {28'h0, level}, 32'h1);
        chk("clean_no_long", lc[0], 0);
        chk("clean_others", pc[1] + pc[2] + pc[3], 0);
        raw = 4'b0000;
        run(300);

        // Long hold on mode
        clr();
        raw  = 4'b0001;
        mark = cyc;
        run(25000);
        chk("long_cnt", lc[0], 1);
        chk("long_at", la[0], mark + 20202);
        raw  = 4'b0000;
        mark = cyc;
        run(300);
        chk("long_rel_cnt", rc[0], 1);
        chk("long_rel_at", ra[0], mark + 202);
        chk("long_no_second", lc[0], 1);

        // Bounce on start, then a clean rise
        clr();
        for (int s = 0; s < 20; s++) begin
            raw[3] = (s % 2 == 0);
            run(50);
        end
        chk("bounce_no_pulse", pc[3] + rc[3] + lc[3], 0);
        chk("bounce_level", {31'h0, level[3]}, 32'h0);
        raw[3] = 1'b1;
        mark   = cyc;
        run(250);
        chk("bounce_press_cnt", pc[3], 1);
        chk("bounce_press_at", pa[3], mark + 202);
        raw = 4'b0000;
        run(250);

        // Simultaneous start and stop
        clr();
        raw  = 4'b1100;
        mark = cyc;
        run(250);
        chk("simul_start_at", pa[3], mark + 202);
        chk("simul_stop_at", pa[2], mark + 202);
        chk("simul_cnts", pc[0] + pc[1] + pc[2] + pc[3], 2);
        raw  = 4'b1000;
        mark = cyc;
        run(250);
        chk("simul_stop_rel_at", ra[2], mark + 202);
        chk("simul_start_no_rel", rc[3], 0);
        chk("simul_levels", {28'h0, level}, 32'h8);
        raw = 4'b0000;
        run(250);

        // Mid-operation reset while power is held
        clr();
        raw = 4'b0010;
        run(10100);
        chk("mrst_first_press", pc[1], 1);
        chk("mrst_no_long_yet", lc[1], 0);
        rst = 1'b1;
        tick();
        chk("mrst_outs", {16'h0, level, press, rel, lng}, 32'h0);
        rst  = 1'b0;
        mark = cyc;
        clr();
        run(20300);
        chk("mrst_press_at", pa[1], mark + 202);
        chk("mrst_press_cnt", pc[1], 1);
        chk("mrst_long_cnt", lc[1], 1);
        chk("mrst_long_at", la[1], mark + 20202);

        chk("exclusivity", excl, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clockbox_btn_conditioner.md
# clockbox_btn_conditioner

Input-conditioning stage of the clockbox: takes the four raw, asynchronous push-button pins (mode, power, stop, start) and turns them into clean, clock-domain signals for the mode/chronometer controller. Per button:
- two-flop synchronization,
- counter-based debouncing,
- single-cycle press and release pulses,
- a single-cycle long-press pulse, which the controller uses for the 2 s mode hold.

Sits directly between the `io_in[3:0]` pins and the controller FSM.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 200: consecutive stable cycles required to accept a level change (20 ms at 10 kHz). Legal range ≥ 2.
- `LONG_CYCLES`, default 20000: cycles a debounced level must stay high before `long_press` fires (2 s at 10 kHz). Must be greater than `DEBOUNCE_CYCLES`.

Ports:
- `clock` in 1: system clock, 10 kHz nominal.
- `reset` in 1: synchronous, active-high.
- `btn_raw` in 4: raw pins, packed as `{start, stop, power, mode}`, i.e. bit 0 = mode. Asynchronous.
- `btn_level` out 4: debounced level per button.
- `press` out 4: one-cycle pulse on each debounced rise.
- `release` out 4: one-cycle pulse on each debounced fall.
- `long_press` out 4: one-cycle pulse when the hold reaches `LONG_CYCLES`.

## Operation
Reset behaviour:
- While `reset` is high, every register clears: sync flops, debounce counter, hold counter and all outputs.
- `reset` asserted mid-operation aborts any pending debounce or hold count on the next edge.

Channels:
- The four channels are identical and fully independent.
- Simultaneous activity on several channels produces simultaneous pulses; there is no priority and no masking.

Synchronizer:
- `sync1 <= btn_raw`, then `sync2 <= sync1`.

Debounce (per channel, counter width `$clog2(DEBOUNCE_CYCLES)`):
- If `sync2 == btn_level`, the counter is cleared to 0.
- Otherwise the counter increments.
- When the counter equals `DEBOUNCE_CYCLES-1` and `sync2 != btn_level`, then on that edge:
  - `btn_level <= sync2`,
  - the counter clears,
  - `press` or `release` pulses according to the direction of the change.
- A glitch shorter than `DEBOUNCE_CYCLES` cycles at `sync2` clears the counter and produces no output change.

Hold (per channel, counter width `$clog2(LONG_CYCLES+1)`):
- Cleared while `btn_level` is 0.
- Increments each cycle while `btn_level` is 1.
- Saturates at `LONG_CYCLES`.
- `long_press` pulses on the edge the counter reaches `LONG_CYCLES`. It fires at most once per press.
- Release clears the counter. If release happens before `LONG_CYCLES`, no long pulse is produced.

Raw held high through reset:
- Treated as a fresh press.
- `press` fires once debounce completes after `reset` falls.

Exclusivity:
- `press` and `release` are never high together on the same channel.
- `long_press` is never coincident with `press`.

## Timing
Define edge 0 as the first rising edge after `reset` low that captures the new raw value into `sync1`.
- Edge 1: `sync2` updates.
- Edge `DEBOUNCE_CYCLES` + 1 (201 by default): `btn_level` changes and the `press`/`release` pulse rises. The pulse lasts exactly one cycle.
- Long-press edge = press edge + `LONG_CYCLES` (20201 by default, counting from raw edge 0).
- All outputs are registered. There is no combinational path from `btn_raw` to any output.

## Structure
- `clockbox_pkg` holds:
  - button index constants `BTN_MODE=0`, `BTN_POWER=1`, `BTN_STOP=2`, `BTN_START=3`,
  - the default cycle constants `CLK_HZ=10000`, `DEBOUNCE_CYCLES_DEF=200`, `LONG_CYCLES_DEF=20000`.
- Sub-module `btn_channel` contains one synchronizer, debounce counter, hold counter and pulse logic. The top level instantiates it 4× in a generate loop.

## Test plan
- **Reset:** hold `reset` 5 cycles with `btn_raw=4'b1111`. Required: all outputs 0 throughout reset. After release, every channel asserts `press` exactly once at edge 201.
- **Clean press:** raise mode (bit 0) and hold it for 10000 cycles. Required:
  - `press[0]` pulses for one cycle at edge 201,
  - `btn_level[0]` is 1 from edge 201 onward,
  - no `long_press`,
  - other channels stay 0.
- **Long hold:** raise mode and hold it for 20000+ cycles, as the controller's 2 s mode-switch hold requires. Required:
  - `long_press[0]` pulses once at edge 20201,
  - no second pulse while still held,
  - `release[0]` occurs 201 edges after the raw fall.
- **Bounce:** toggle start (bit 3) 0/1 every 50 cycles for 1000 cycles, then hold it at 1. Required: no pulse during bouncing; exactly one `press[3]` 201 edges after the final rise.
- **Simultaneous:** raise start and stop on the same cycle. Required:
  - `press[3]` and `press[2]` pulse on the same edge (201),
  - releasing only stop yields `release[2]` alone, with `btn_level[3]` unaffected.
- **Mid-operation reset:** hold power for 10100 cycles, assert `reset` for 1 cycle, keep power high. Required:
  - all outputs are 0 on the edge after `reset` is sampled,
  - a fresh `press[1]` occurs 201 edges after `reset` falls,
  - `long_press[1]` timing restarts from that new press.
